// File: rtl/axis_image_dw_downsizer.sv
// -----------------------------------------------------------------------------
// axis_image_dw_downsizer
//
// Repacks an AXI-Stream image from SW-word input beats into UE-word output
// beats (UE = UNITS + KERNEL_H_MAX - 1, SW = next power of two >= UE).
// Input words are appended to a word FIFO, and whole UE-word groups are
// emitted from its head. The final group of an image is zero-padded and
// carries tlast. An image with no words at all still produces one all-zero
// tlast beat. After an image's tlast is accepted, input stays blocked until
// that image's last output beat has been handed off.
//
// Ports
//   aclk, aresetn   clock, asynchronous active-low reset
//   s_axis_*        input stream  (tdata SW words, tkeep per byte, tlast)
//   m_axis_*        output stream (tdata UE words, tlast)
//   Word 0 sits in the least significant bits and is the earliest word.
// -----------------------------------------------------------------------------
module axis_image_dw_downsizer #(
   parameter  int UNITS        = 2,
   parameter  int WORD_WIDTH   = 8,
   parameter  int KERNEL_H_MAX = 3,
   localparam int UE           = UNITS + KERNEL_H_MAX - 1,
   localparam int SW           = 2 ** $clog2(UE),
   localparam int BUF_WORDS    = SW + UE - 1,
   localparam int KW           = SW * WORD_WIDTH / 8
) (
   input  logic                       aclk,
   input  logic                       aresetn,
   output logic                       s_axis_tready,
   input  logic                       s_axis_tvalid,
   input  logic [WORD_WIDTH*SW-1:0]   s_axis_tdata,
   input  logic [KW-1:0]              s_axis_tkeep,
   input  logic                       s_axis_tlast,
   input  logic                       m_axis_tready,
   output logic                       m_axis_tvalid,
   output logic [WORD_WIDTH*UE-1:0]   m_axis_tdata,
   output logic                       m_axis_tlast
);

   localparam int WB  = WORD_WIDTH / 8;
   localparam int CW  = $clog2(BUF_WORDS + 1);
   localparam int BIW = (BUF_WORDS > 1) ? $clog2(BUF_WORDS) : 1;
   localparam int SIW = (SW > 1) ? $clog2(SW) : 1;

   typedef enum logic {
      ST_STREAM,
      ST_LAST
   } state_t;

   state_t                  state;
   state_t                  state_next;

   logic [CW-1:0]           cnt;
   logic [CW-1:0]           cnt_next;
   logic [WORD_WIDTH-1:0]   buf_q    [BUF_WORDS];
   logic [WORD_WIDTH-1:0]   buf_next [BUF_WORDS];
   logic [WORD_WIDTH-1:0]   in_word  [SW];

   logic                    last_pending;
   logic                    in_fire;
   logic                    out_fire;

   int unsigned             occ;
   int unsigned             avail;
   int unsigned             kept;
   int unsigned             popped;
   int unsigned             pushed;
   int unsigned             remain;

   assign in_fire  = s_axis_tvalid && s_axis_tready;
   assign out_fire = m_axis_tvalid && m_axis_tready;

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state <= ST_STREAM;
      end else begin
         state <= state_next;
      end
   end

   // ---------------------------------------------------------------- next state
   // ST_LAST marks "tlast accepted, final output beat not yet handed off".
   always_comb begin
      state_next = state;
      case (state)
         ST_STREAM: if (in_fire && s_axis_tlast)  state_next = ST_LAST;
         ST_LAST:   if (out_fire && m_axis_tlast) state_next = ST_STREAM;
         default:   state_next = ST_STREAM;
      endcase
   end

   // ---------------------------------------------------------------- outputs
   // Everything below derives from registered state, so the reset values
   // appear asynchronously; s_axis_tready is additionally gated by aresetn.
   always_comb begin
      last_pending  = (state == ST_LAST);
      occ           = 32'(cnt);
      avail         = (occ > UE) ? UE : occ;
      m_axis_tvalid = (occ >= UE) || last_pending;
      m_axis_tlast  = last_pending && (occ <= UE);
      m_axis_tdata  = '0;
      for (int unsigned i = 0; i < UE; i++) begin
         if (i < occ) m_axis_tdata[i*WORD_WIDTH +: WORD_WIDTH] = buf_q[i];
      end
      // Accept while a full input beat is guaranteed to fit after any pop
      // happening in the same cycle.
      s_axis_tready = aresetn && !last_pending &&
                      ((occ < UE) || ((occ < 2 * UE) && m_axis_tready));
   end

   // ---------------------------------------------------------------- datapath
   // Pop and push are merged into one step: surviving words shift down by the
   // popped amount, kept input words land right behind them, and every slot
   // past the new occupancy is cleared.
   always_comb begin
      kept = 0;
      for (int unsigned i = 0; i < SW; i++) begin
         in_word[i] = s_axis_tdata[i*WORD_WIDTH +: WORD_WIDTH];
         if (&s_axis_tkeep[i*WB +: WB]) kept = kept + 1;
      end
      popped = out_fire ? avail : 0;
      remain = occ - popped;
      pushed = in_fire ? kept : 0;
      for (int unsigned i = 0; i < BUF_WORDS; i++) begin
         buf_next[i] = '0;
         if (i < remain) begin
            buf_next[i] = buf_q[BIW'(i + popped)];
         end else if ((i - remain) < pushed) begin
            buf_next[i] = in_word[SIW'(i - remain)];
         end
      end
      cnt_next = CW'(remain + pushed);
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         cnt <= '0;
         for (int unsigned i = 0; i < BUF_WORDS; i++) buf_q[i] <= '0;
      end else begin
         cnt <= cnt_next;
         for (int unsigned i = 0; i < BUF_WORDS; i++) buf_q[i] <= buf_next[i];
      end
   end

endmodule

// File: doc/axis_image_dw_downsizer.md
AXIS_IMAGE_DW_DOWNSIZER -- requirements
Module: axis_image_dw_downsizer

Interface
REQ-001 SHALL have parameter UNITS, default 2, number of conv units.
REQ-002 SHALL have parameter WORD_WIDTH, default 8, bits per pixel word; a multiple of 8.
REQ-003 SHALL have parameter KERNEL_H_MAX, default 3, odd maximum kernel height.
REQ-004 SHALL derive localparams:
- UE = UNITS+KERNEL_H_MAX-1.
- SW = 2**$clog2(UE).
- BUF_WORDS = SW+UE-1.
- KW = SW*WORD_WIDTH/8.
REQ-005 SHALL have port aclk, input, 1, sole clock; all state on rising edge.
REQ-006 SHALL have port aresetn, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have port s_axis_tready, output, 1, input beat accepted when high with tvalid.
REQ-008 SHALL have port s_axis_tvalid, input, 1, input beat valid.
REQ-009 SHALL have port s_axis_tdata, input, WORD_WIDTH*SW, word i at bits [i*WORD_WIDTH +: WORD_WIDTH]; word 0 is earliest.
REQ-010 SHALL have port s_axis_tkeep, input, KW, byte enables.
REQ-011 SHALL have port s_axis_tlast, input, 1, last beat of image.
REQ-012 SHALL have port m_axis_tready, input, 1, downstream ready (image pipe).
REQ-013 SHALL have port m_axis_tvalid, output, 1, output beat valid.
REQ-014 SHALL have port m_axis_tdata, output, WORD_WIDTH*UE, same word order as input.
REQ-015 SHALL have port m_axis_tlast, output, 1, final beat of image.

Function
REQ-016 SHALL treat word i as kept when all its tkeep bits are 1.
- Kept words SHALL be contiguous from word 0; other patterns are out of contract.
- Partial keep is allowed on any beat.
REQ-017 SHALL hold a word FIFO buffer of BUF_WORDS words with occupancy count C, width $clog2(BUF_WORDS+1).
REQ-018 SHALL set m_axis_tvalid = (C >= UE) || LP, where LP is the last-pending flag.
REQ-019 SHALL set m_axis_tdata from the oldest min(C,UE) buffered words, oldest at word 0.
- Word positions >= C SHALL be zero.
REQ-020 SHALL set m_axis_tlast = LP && (C <= UE).
REQ-021 On an output handshake, SHALL remove min(C,UE) words and compact the remainder toward word 0.
REQ-022 SHALL drive s_axis_tready = !LP && ((C < UE) || (C < 2*UE && m_axis_tready)).
- This is a combinational path from m_axis_tready, permitted.
REQ-023 On an input handshake, SHALL append the kept words after the remaining words in the same cycle, so pop and push may coincide.
- C_next = C - popped + kept; C_next SHALL never exceed BUF_WORDS.
REQ-024 SHALL set LP on an accepted beat with tlast.
- LP SHALL clear on the output handshake where m_axis_tlast=1.
REQ-025 With LP=1 and C=0, SHALL emit one all-zero beat with tlast=1, so every image yields at least one tlast beat.
REQ-026 SHALL NOT emit an extra beat when the image word total is an exact multiple of UE; tlast rides on the final full beat.
REQ-027 Latency: SHALL present a word accepted in cycle N on m_axis no earlier than cycle N+1; no combinational s_axis_tdata to m_axis_tdata path.
REQ-028 SHALL hold m_axis_tdata and m_axis_tlast stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-029 SHALL NOT accept the next image until the previous tlast beat is handed off.
REQ-030 When UE == SW, SHALL behave as a 1-beat registered pass-through.
- Output SHALL be full-rate with m_axis_tready held 1.

Reset
REQ-031 While aresetn=0, SHALL drive outputs asynchronously to: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, s_axis_tready=0.
- C=0, LP=0, buffer zero.
REQ-032 On reset mid-image, SHALL discard all buffered words.
- After release, s_axis_tready=1 in the first cycle.
- The next accepted beat SHALL start a new image.

Verification (UNITS=8, KERNEL_H_MAX=3 → UE=10, SW=16, unless noted)
REQ-033 SHALL cover: 5 full beats, words 0..79, tlast on beat 5, m_tready=1 -> 8 beats of 0..9 … 70..79; tlast only on 8th.
REQ-034 SHALL cover: beat 1 full, beat 2 tkeep = words 0..3 with tlast (20 words) -> exactly 2 beats; second = 10..19, tlast=1.
REQ-035 SHALL cover: 17 words (16 + 1 with tlast) -> beat 1 = 0..9; beat 2 = 10..16, three zero words, tlast=1.
REQ-036 SHALL cover: random m_tready (50%) and s_tvalid over 3 images -> output identical to REQ-033 reference, no loss or duplication, tdata stable under stall, s_tready low throughout LP.
REQ-037 SHALL cover: a lone tlast beat with tkeep=0 at C=0 -> one all-zero beat, tlast=1, then s_tready=1.
REQ-038 SHALL cover:
- Reset asserted after 2 beats of an image -> m_tvalid=0 immediately; the following 1-beat tlast image outputs only its own words.
- UNITS=2 config -> 1:1 pass-through, 1-cycle latency.
